// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  // Controller states. The 2-bit encoding is fixed so that state values read
  // the same way in every build.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Default operand width. It matches the neighbouring 4-bit multiplier.
  localparam int DIV_WIDTH_DFLT = 4;

  // Width of the step counter. It must be able to count WIDTH restoring steps.
  function automatic int step_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_4bit_seq_if.sv
// Request/result bundle for div_4bit_seq. The requester drives start and the
// operands. The divider returns status and results.
interface div_4bit_seq_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DFLT
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step. It shifts the next dividend bit
// into the partial remainder, then subtracts the divisor when the result is
// large enough.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);
  // The full partial remainder is carried through the shift. Its top bit is
  // always zero between steps, so the final truncation loses nothing.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] dvs_ext;

  assign shifted = {rem_i, bit_i};
  assign dvs_ext = {2'b00, dvs_i};

  // Restoring step: subtract only when the result stays non-negative.
  always_comb begin
    if (shifted >= dvs_ext) begin
      rem_o = (WIDTH+1)'(shifted - dvs_ext);
      q_o   = 1'b1;
    end else begin
      rem_o = (WIDTH+1)'(shifted);
      q_o   = 1'b0;
    end
  end
endmodule

// File: rtl/div_4bit_seq.sv
// Iterative unsigned restoring divider. It produces one quotient bit per clock,
// MSB first, and pulses done for one cycle when quotient/remainder are valid.
// Optional feature: define DIV_ZERO_FAST_EN to short-circuit a zero divisor
// straight to DONE and flag it on div_by_zero.
module div_4bit_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DFLT
) (
  input  logic            clk,
  input  logic            rst,
  div_4bit_seq_if.slave   bus
);
  localparam int CW = step_cnt_w(WIDTH);

  div_state_e       state_q,     state_d;
  logic [WIDTH-1:0] dvd_q,       dvd_d;        // dividend shift register, MSB consumed first
  logic [WIDTH-1:0] dvs_q,       dvs_d;        // divisor captured at start
  logic [WIDTH:0]   rem_q,       rem_d;        // partial remainder
  logic [WIDTH-1:0] quo_q,       quo_d;        // quotient bits collected so far
  logic [CW-1:0]    cnt_q,       cnt_d;        // restoring steps completed
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
`ifdef DIV_ZERO_FAST_EN
  logic             dbz_q,       dbz_d;
`endif

  logic [WIDTH:0]   step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // State and datapath registers. The synchronous reset discards any
  // operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: every sequential update uses <= so that all flops sample values
    // from before the edge, regardless of the statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIV_ZERO_FAST_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef DIV_ZERO_FAST_EN
      dbz_q       <= dbz_d;
`endif
    end
  end

  // Next-state and datapath update. Results load only when DONE is entered.
  always_comb begin
    // NOTE: every signal gets a hold default first. Any branch that skips one
    // of them then still leaves it defined, so no latch is inferred.
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIV_ZERO_FAST_EN
    dbz_d       = dbz_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
`ifdef DIV_ZERO_FAST_EN
          dbz_d   = 1'b0;
          if (bus.divisor == '0) begin
            state_d     = ST_DONE;
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
          end
`endif
        end
      end
      ST_RUN: begin
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = ST_DONE;
          quotient_d  = quo_d;
          remainder_d = step_rem[WIDTH-1:0];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: the status comes from the state, and the results come from the
  // held registers.
  always_comb begin
    bus.busy      = (state_q != ST_IDLE);
    bus.done      = (state_q == ST_DONE);
    bus.quotient  = quotient_q;
    bus.remainder = remainder_q;
`ifdef DIV_ZERO_FAST_EN
    bus.div_by_zero = dbz_q;
`else
    bus.div_by_zero = 1'b0;
`endif
  end
endmodule
